// File: rtl/hazard_ctrl.sv
// hazard_ctrl: pipeline hazard controller for the 5-stage core.
// Produces EX operand forwarding selects, load-use stall, jump squash,
// data-memory wait freeze with timeout-to-halt, and a saturating
// stall-cycle counter.
module hazard_ctrl #(
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [4:0]       rs1D,
    input  logic [4:0]       rs2D,
    input  logic [4:0]       rs1E,
    input  logic [4:0]       rs2E,
    input  logic [4:0]       rdE,
    input  logic             regwriteE,
    input  logic [1:0]       wbselE,
    input  logic             pcselE,
    input  logic [4:0]       rdM,
    input  logic             regwriteM,
    input  logic [4:0]       rdW,
    input  logic             regwriteW,
    input  logic             dmem_req,
    input  logic             dmem_ready,
    input  logic             err_clr,
    output logic [1:0]       fwdAE,
    output logic [1:0]       fwdBE,
    output logic             stallF,
    output logic             stallD,
    output logic             stallE,
    output logic             stallM,
    output logic             flushD,
    output logic             flushE,
    output logic             halted,
    output logic [CNT_W-1:0] stall_cycles
);

    localparam int WC_W = (MEM_TIMEOUT > 2) ? $clog2(MEM_TIMEOUT) : 1;
    localparam logic [WC_W-1:0] WC_LAST = WC_W'(MEM_TIMEOUT - 1);

    typedef enum logic [1:0] {
        RUN  = 2'd0,
        WAIT = 2'd1,
        HALT = 2'd2
    } state_t;

    state_t            r_state;
    state_t            w_state_next;
    logic [WC_W-1:0]   r_wait_cnt;
    logic [WC_W-1:0]   w_wait_cnt_next;
    logic [CNT_W-1:0]  r_stall_cnt;

    logic              w_lu;
    logic              w_mw;

    // Forwarding: one identical select per EX source operand; MEM beats WB,
    // and x0 is never forwarded.
    logic [4:0] w_src [2];
    logic [1:0] w_fwd [2];

    assign w_src[0] = rs1E;
    assign w_src[1] = rs2E;

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_fwd
            assign w_fwd[gi] =
                (regwriteM && (rdM != 5'd0) && (rdM == w_src[gi])) ? 2'b10 :
                (regwriteW && (rdW != 5'd0) && (rdW == w_src[gi])) ? 2'b01 :
                                                                      2'b00;
        end
    endgenerate

    assign fwdAE = w_fwd[0];
    assign fwdBE = w_fwd[1];

    // Hazard terms: load in EX feeding DECODE, and MEM access not yet done.
    assign w_lu = regwriteE && (wbselE == 2'b00) && (rdE != 5'd0) &&
                  ((rdE == rs1D) || (rdE == rs2D));
    assign w_mw = dmem_req && !dmem_ready;

    // State and wait-counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= RUN;
            r_wait_cnt <= '0;
        end else begin
            r_state    <= w_state_next;
            r_wait_cnt <= w_wait_cnt_next;
        end
    end

    // Next state: count consecutive not-ready cycles, halt on the last allowed one.
    always_comb begin
        w_state_next    = r_state;
        w_wait_cnt_next = r_wait_cnt;
        case (r_state)
            HALT: begin
                if (err_clr) begin
                    w_state_next    = RUN;
                    w_wait_cnt_next = '0;
                end
            end
            default: begin
                if (w_mw) begin
                    if (r_wait_cnt == WC_LAST) begin
                        w_state_next    = HALT;
                        w_wait_cnt_next = '0;
                    end else begin
                        w_state_next    = WAIT;
                        w_wait_cnt_next = r_wait_cnt + WC_W'(1);
                    end
                end else begin
                    w_state_next    = RUN;
                    w_wait_cnt_next = '0;
                end
            end
        endcase
    end

    // Stall/flush outputs in priority order: halt, memory wait, jump, load-use.
    always_comb begin
        stallF = 1'b0;
        stallD = 1'b0;
        stallE = 1'b0;
        stallM = 1'b0;
        flushD = 1'b0;
        flushE = 1'b0;
        halted = 1'b0;
        if (r_state == HALT) begin
            stallF = 1'b1;
            stallD = 1'b1;
            stallE = 1'b1;
            stallM = 1'b1;
            halted = 1'b1;
        end else if (w_mw) begin
            stallF = 1'b1;
            stallD = 1'b1;
            stallE = 1'b1;
            stallM = 1'b1;
        end else if (pcselE) begin
            flushD = 1'b1;
            flushE = 1'b1;
        end else if (w_lu) begin
            stallF = 1'b1;
            stallD = 1'b1;
            flushE = 1'b1;
        end
    end

    // Saturating count of cycles in which the PC is held.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stall_cnt <= '0;
        end else if (stallF && (r_stall_cnt != {CNT_W{1'b1}})) begin
            r_stall_cnt <= r_stall_cnt + CNT_W'(1);
        end
    end

    assign stall_cycles = r_stall_cnt;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed testbench for hazard_ctrl. Inputs change on the falling edge;
// outputs are checked 1ns later, well away from the rising edge.
module tb_hazard_ctrl;

    localparam int MEM_TIMEOUT = 16;
    localparam int CNT_W       = 8;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [4:0]       rs1D, rs2D, rs1E, rs2E, rdE, rdM, rdW;
    logic             regwriteE, regwriteM, regwriteW, pcselE;
    logic [1:0]       wbselE;
    logic             dmem_req, dmem_ready, err_clr;
    logic [1:0]       fwdAE, fwdBE;
    logic             stallF, stallD, stallE, stallM, flushD, flushE, halted;
    logic [CNT_W-1:0] stall_cycles;

    // {stallF,stallD,stallE,stallM,flushD,flushE,halted}
    logic [6:0] ctl;
    assign ctl = {stallF, stallD, stallE, stallM, flushD, flushE, halted};

    localparam logic [6:0] C_NONE = 7'b0000000;
    localparam logic [6:0] C_LU   = 7'b1100010;
    localparam logic [6:0] C_JMP  = 7'b0000110;
    localparam logic [6:0] C_MW   = 7'b1111000;
    localparam logic [6:0] C_HALT = 7'b1111001;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    hazard_ctrl #(.MEM_TIMEOUT(MEM_TIMEOUT), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .rs1D(rs1D), .rs2D(rs2D), .rs1E(rs1E), .rs2E(rs2E), .rdE(rdE),
        .regwriteE(regwriteE), .wbselE(wbselE), .pcselE(pcselE),
        .rdM(rdM), .regwriteM(regwriteM), .rdW(rdW), .regwriteW(regwriteW),
        .dmem_req(dmem_req), .dmem_ready(dmem_ready), .err_clr(err_clr),
        .fwdAE(fwdAE), .fwdBE(fwdBE),
        .stallF(stallF), .stallD(stallD), .stallE(stallE), .stallM(stallM),
        .flushD(flushD), .flushE(flushE), .halted(halted),
        .stall_cycles(stall_cycles)
    );

    task automatic clear_inputs();
        rs1D = 0; rs2D = 0; rs1E = 0; rs2E = 0; rdE = 0; rdM = 0; rdW = 0;
        regwriteE = 0; regwriteM = 0; regwriteW = 0; pcselE = 0; wbselE = 2'b11;
        dmem_req = 0; dmem_ready = 0; err_clr = 0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        clear_inputs();
        #1;
        n_vec++;
        if (ctl !== C_NONE || stall_cycles !== 8'd0 || fwdAE !== 2'b00 || fwdBE !== 2'b00) begin
            n_err++;
            $display("FAIL reset: ctl=%b cnt=%0d fwdA=%b fwdB=%b, need ctl=%b cnt=0 fwd=00",
                     ctl, stall_cycles, fwdAE, fwdBE, C_NONE);
        end
        @(negedge clk); @(negedge clk);
        rst_n = 1'b1;
        #1;
        n_vec++;
        if (ctl !== C_NONE || stall_cycles !== 8'd0) begin
            n_err++;
            $display("FAIL reset_release: ctl=%b cnt=%0d, need %b 0", ctl, stall_cycles, C_NONE);
        end
        $display("reset: ctl=%b cnt=%0d", ctl, stall_cycles);
    endtask

    task automatic test_forwarding();
        // {regwriteM,rdM,regwriteW,rdW,rs1E,rs2E} -> {fwdA,fwdB}
        logic [21:0] vin  [6];
        logic [3:0]  vexp [6];
        vin[0] = {1'b1, 5'd5, 1'b1, 5'd5, 5'd5, 5'd6};  vexp[0] = 4'b10_00;
        vin[1] = {1'b1, 5'd0, 1'b1, 5'd5, 5'd5, 5'd6};  vexp[1] = 4'b01_00;
        vin[2] = {1'b1, 5'd9, 1'b1, 5'd5, 5'd5, 5'd9};  vexp[2] = 4'b01_10;
        vin[3] = {1'b0, 5'd5, 1'b1, 5'd5, 5'd5, 5'd5};  vexp[3] = 4'b01_01;
        vin[4] = {1'b1, 5'd0, 1'b1, 5'd0, 5'd0, 5'd0};  vexp[4] = 4'b00_00;
        vin[5] = {1'b1, 5'd3, 1'b0, 5'd4, 5'd4, 5'd3};  vexp[5] = 4'b00_10;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            {regwriteM, rdM, regwriteW, rdW, rs1E, rs2E} = vin[i];
            #1;
            n_vec++;
            if ({fwdAE, fwdBE} !== vexp[i]) begin
                n_err++;
                $display("FAIL fwd[%0d]: got A=%b B=%b, need A=%b B=%b",
                         i, fwdAE, fwdBE, vexp[i][3:2], vexp[i][1:0]);
            end
            $display("fwd[%0d]: A=%b B=%b", i, fwdAE, fwdBE);
        end
        @(negedge clk);
        clear_inputs();
    endtask

    task automatic test_load_use();
        // Non-hazards first: x0 destination, and a non-load writeback select.
        @(negedge clk);
        regwriteE = 1; wbselE = 2'b00; rdE = 5'd0; rs1D = 5'd0;
        #1;
        n_vec++;
        if (ctl !== C_NONE) begin
            n_err++;
            $display("FAIL lu_x0: ctl=%b, need %b", ctl, C_NONE);
        end
        @(negedge clk);
        rdE = 5'd7; rs2D = 5'd7; wbselE = 2'b01;
        #1;
        n_vec++;
        if (ctl !== C_NONE) begin
            n_err++;
            $display("FAIL lu_nonload: ctl=%b, need %b", ctl, C_NONE);
        end
        // Real load-use.
        @(negedge clk);
        wbselE = 2'b00;
        #1;
        n_vec++;
        if (ctl !== C_LU) begin
            n_err++;
            $display("FAIL lu: ctl=%b, need %b", ctl, C_LU);
        end
        $display("load_use: ctl=%b", ctl);
        // Pipeline has moved: load left EX.
        @(negedge clk);
        clear_inputs();
        #1;
        n_vec++;
        if (ctl !== C_NONE || stall_cycles !== 8'd1) begin
            n_err++;
            $display("FAIL lu_after: ctl=%b cnt=%0d, need %b 1", ctl, stall_cycles, C_NONE);
        end
        $display("load_use_after: ctl=%b cnt=%0d", ctl, stall_cycles);
    endtask

    task automatic test_jump_vs_lu();
        @(negedge clk);
        regwriteE = 1; wbselE = 2'b00; rdE = 5'd7; rs2D = 5'd7; pcselE = 1;
        #1;
        n_vec++;
        if (ctl !== C_JMP) begin
            n_err++;
            $display("FAIL jump_lu: ctl=%b, need %b", ctl, C_JMP);
        end
        @(negedge clk);
        clear_inputs();
        #1;
        n_vec++;
        if (ctl !== C_NONE || stall_cycles !== 8'd1) begin
            n_err++;
            $display("FAIL jump_after: ctl=%b cnt=%0d, need %b 1", ctl, stall_cycles, C_NONE);
        end
        $display("jump_vs_lu: cnt=%0d", stall_cycles);
    endtask

    task automatic test_mem_wait();
        // Three not-ready cycles; the first also carries a jump and a load-use.
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            dmem_req = 1; dmem_ready = 0;
            if (i == 0) begin
                pcselE = 1; regwriteE = 1; wbselE = 2'b00; rdE = 5'd4; rs1D = 5'd4;
            end else begin
                pcselE = 0; regwriteE = 0;
            end
            #1;
            n_vec++;
            if (ctl !== C_MW) begin
                n_err++;
                $display("FAIL memwait[%0d]: ctl=%b, need %b", i, ctl, C_MW);
            end
        end
        @(negedge clk);
        dmem_ready = 1;
        #1;
        n_vec++;
        if (ctl !== C_NONE) begin
            n_err++;
            $display("FAIL memwait_ready: ctl=%b, need %b", ctl, C_NONE);
        end
        @(negedge clk);
        clear_inputs();
        #1;
        n_vec++;
        if (ctl !== C_NONE || stall_cycles !== 8'd4) begin
            n_err++;
            $display("FAIL memwait_after: ctl=%b cnt=%0d, need %b 4", ctl, stall_cycles, C_NONE);
        end
        $display("mem_wait: cnt=%0d", stall_cycles);
    endtask

    task automatic test_timeout();
        int bad;
        bad = 0;
        for (int i = 0; i < MEM_TIMEOUT; i++) begin
            @(negedge clk);
            dmem_req = 1; dmem_ready = 0;
            #1;
            if (ctl !== C_MW) bad++;
        end
        n_vec++;
        if (bad != 0) begin
            n_err++;
            $display("FAIL timeout_stall: %0d of %0d cycles not plain stall, need 0", bad, MEM_TIMEOUT);
        end
        @(negedge clk);
        dmem_req = 0;
        #1;
        n_vec++;
        if (ctl !== C_HALT) begin
            n_err++;
            $display("FAIL timeout_halt: ctl=%b, need %b", ctl, C_HALT);
        end
        $display("timeout: ctl=%b", ctl);
        @(negedge clk);
        err_clr = 1;
        #1;
        n_vec++;
        if (ctl !== C_HALT) begin
            n_err++;
            $display("FAIL halt_hold: ctl=%b, need %b", ctl, C_HALT);
        end
        @(negedge clk);
        err_clr = 0;
        #1;
        n_vec++;
        if (ctl !== C_NONE || stall_cycles !== 8'd22) begin
            n_err++;
            $display("FAIL err_clr: ctl=%b cnt=%0d, need %b 22", ctl, stall_cycles, C_NONE);
        end
        $display("err_clr: ctl=%b cnt=%0d", ctl, stall_cycles);
        // Ready arrives in the last allowed cycle: no halt.
        for (int i = 0; i < MEM_TIMEOUT - 1; i++) begin
            @(negedge clk);
            dmem_req = 1; dmem_ready = 0;
        end
        @(negedge clk);
        dmem_ready = 1;
        #1;
        n_vec++;
        if (ctl !== C_NONE) begin
            n_err++;
            $display("FAIL last_ready: ctl=%b, need %b", ctl, C_NONE);
        end
        @(negedge clk);
        clear_inputs();
        #1;
        n_vec++;
        if (ctl !== C_NONE || stall_cycles !== 8'd37) begin
            n_err++;
            $display("FAIL last_ready_after: ctl=%b cnt=%0d, need %b 37", ctl, stall_cycles, C_NONE);
        end
        $display("last_ready: ctl=%b cnt=%0d", ctl, stall_cycles);
    endtask

    task automatic test_async_reset();
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            dmem_req = 1; dmem_ready = 0;
        end
        @(negedge clk);
        #2;
        n_vec++;
        if (stall_cycles !== 8'd42) begin
            n_err++;
            $display("FAIL pre_reset_cnt: cnt=%0d, need 42", stall_cycles);
        end
        rst_n = 0; dmem_req = 0;
        #1;
        n_vec++;
        if (ctl !== C_NONE || stall_cycles !== 8'd0) begin
            n_err++;
            $display("FAIL async_reset: ctl=%b cnt=%0d, need %b 0", ctl, stall_cycles, C_NONE);
        end
        $display("async_reset: ctl=%b cnt=%0d", ctl, stall_cycles);
        @(negedge clk);
        rst_n = 1;
        // Wait state must also be gone: one more not-ready cycle is a plain stall.
        dmem_req = 1;
        #1;
        n_vec++;
        if (ctl !== C_MW) begin
            n_err++;
            $display("FAIL after_reset_mw: ctl=%b, need %b", ctl, C_MW);
        end
        @(negedge clk);
        clear_inputs();
    endtask

    task automatic test_saturate();
        // Hold memory not-ready: 16 wait cycles then HALT, stallF stays high.
        @(negedge clk);
        rst_n = 0;
        #1;
        rst_n = 1;
        dmem_req = 1; dmem_ready = 0;
        for (int k = 1; k <= 259; k++) begin
            @(negedge clk);
            #1;
            if (k == 254) begin
                n_vec++;
                if (stall_cycles !== 8'hFE) begin
                    n_err++;
                    $display("FAIL sat_254: cnt=%0d, need 254", stall_cycles);
                end
            end
        end
        n_vec++;
        if (stall_cycles !== 8'hFF || ctl !== C_HALT) begin
            n_err++;
            $display("FAIL saturate: cnt=%0d ctl=%b, need 255 %b", stall_cycles, ctl, C_HALT);
        end
        $display("saturate: cnt=%0d ctl=%b", stall_cycles, ctl);
        #2;
        rst_n = 0; dmem_req = 0;
        #1;
        n_vec++;
        if (ctl !== C_NONE || stall_cycles !== 8'd0) begin
            n_err++;
            $display("FAIL halt_reset: ctl=%b cnt=%0d, need %b 0", ctl, stall_cycles, C_NONE);
        end
        $display("halt_reset: ctl=%b cnt=%0d", ctl, stall_cycles);
        @(negedge clk);
        rst_n = 1;
    endtask

    initial begin
        test_reset();
        test_forwarding();
        test_load_use();
        test_jump_vs_lu();
        test_mem_wait();
        test_timeout();
        test_async_reset();
        test_saturate();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
